prim_ram_2p_ctrl: RTL and testbench

Single-clock controller placed in front of one port of `prim_ram_2p`. After reset, and again on request, it sweeps the whole array and writes a fixed init value. Once the sweep finishes, it shares the port between two host requesters through a round-robin arbiter with a req/gnt/rvalid handshake. Read data returns one cycle after grant, matching the registered read of the RAM.

---
 rtl/prim_ram_2p_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_prim_ram_2p_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_ram_2p_ctrl.sv
// rtl/prim_ram_2p_ctrl.sv - init sweep and two-host round-robin front end for one prim_ram_2p port
//
// After reset, or after an init_req_i pulse while serving, every word of the RAM
// is written with InitValue. When the sweep completes, two hosts share the port
// through a round-robin arbiter. Grants are combinational, and read data returns
// one cycle after the grant.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   init_req_i              single-cycle re-initialisation request (honoured in SERVE only)
//   init_done_o             array initialised, hosts being served
//   hostN_req_i             access request, held until granted
//   hostN_write_i           1 = write, 0 = read
//   hostN_addr_i            word address (< Depth)
//   hostN_wdata_i           write data
//   hostN_gnt_o             request accepted this cycle
//   hostN_rvalid_o          read data valid (one cycle after a granted read)
//   hostN_rdata_o           read data (shared RAM read bus)
//   ram_req_o, ram_write_o  RAM port request / write enable
//   ram_addr_o              RAM port address
//   ram_wdata_o             RAM port write data
//   ram_rdata_i             RAM read data, valid the cycle after a read request

module prim_ram_2p_ctrl #(
   parameter int                 Width     = 32,
   parameter int                 Depth     = 128,
   parameter logic [Width-1:0]   InitValue = '0,
   localparam int                Aw        = ($clog2(Depth) > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             init_req_i,
   output logic             init_done_o,

   input  logic             host0_req_i,
   input  logic             host0_write_i,
   input  logic [Aw-1:0]    host0_addr_i,
   input  logic [Width-1:0] host0_wdata_i,
   output logic             host0_gnt_o,
   output logic             host0_rvalid_o,
   output logic [Width-1:0] host0_rdata_o,

   input  logic             host1_req_i,
   input  logic             host1_write_i,
   input  logic [Aw-1:0]    host1_addr_i,
   input  logic [Width-1:0] host1_wdata_i,
   output logic             host1_gnt_o,
   output logic             host1_rvalid_o,
   output logic [Width-1:0] host1_rdata_o,

   output logic             ram_req_o,
   output logic             ram_write_o,
   output logic [Aw-1:0]    ram_addr_o,
   output logic [Width-1:0] ram_wdata_o,
   input  logic [Width-1:0] ram_rdata_i
);

   typedef enum logic [1:0] {
      StBoot  = 2'd0,
      StInit  = 2'd1,
      StServe = 2'd2
   } state_e;

   // Comparing against Depth-1 (not relying on wrap) keeps non-power-of-two
   // depths from ever addressing past the end of the array.
   localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

   state_e          state_q, state_d;
   logic [Aw-1:0]   init_cnt_q, init_cnt_d;
   logic            rvalid_q, rvalid_d;
   logic            rid_q, rid_d;
   logic            last_q, last_d;

   logic            serve_en;
   logic            gnt0, gnt1;

   // -------------------------------------------------------------------------
   // Round-robin arbiter. last_q holds the most recently granted host; on
   // contention the other host wins. A re-init request suppresses all grants
   // in its trigger cycle so nothing races the sweep.
   // -------------------------------------------------------------------------
   always_comb begin
      serve_en = (state_q == StServe) && !init_req_i;
      gnt0     = serve_en && host0_req_i && (!host1_req_i || last_q);
      gnt1     = serve_en && host1_req_i && (!host0_req_i || !last_q);
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      rvalid_d   = 1'b0;
      rid_d      = rid_q;
      last_d     = last_q;

      unique case (state_q)
         StBoot: begin
            state_d = StInit;
         end
         StInit: begin
            if (init_cnt_q == LastAddr) begin
               init_cnt_d = '0;
               state_d    = StServe;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end
         StServe: begin
            if (init_req_i) begin
               state_d = StInit;
            end
            if (gnt0) begin
               last_d   = 1'b0;
               rvalid_d = !host0_write_i;
               if (!host0_write_i) rid_d = 1'b0;
            end else if (gnt1) begin
               last_d   = 1'b1;
               rvalid_d = !host1_write_i;
               if (!host1_write_i) rid_d = 1'b1;
            end
         end
         default: begin
            state_d = StBoot;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers. Reset lands in BOOT so no RAM access can occur while
   // rst_i is high; any read in flight is dropped.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StBoot;
         init_cnt_q <= '0;
         rvalid_q   <= 1'b0;
         rid_q      <= 1'b0;
         last_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         rvalid_q   <= rvalid_d;
         rid_q      <= rid_d;
         last_q     <= last_d;
      end
   end

   // -------------------------------------------------------------------------
   // RAM port mux: the sweep owns the port in INIT, the granted host in SERVE.
   // -------------------------------------------------------------------------
   always_comb begin
      ram_req_o   = 1'b0;
      ram_write_o = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;

      if (state_q == StInit) begin
         ram_req_o   = 1'b1;
         ram_write_o = 1'b1;
         ram_addr_o  = init_cnt_q;
         ram_wdata_o = InitValue;
      end else if (gnt0) begin
         ram_req_o   = 1'b1;
         ram_write_o = host0_write_i;
         ram_addr_o  = host0_addr_i;
         ram_wdata_o = host0_wdata_i;
      end else if (gnt1) begin
         ram_req_o   = 1'b1;
         ram_write_o = host1_write_i;
         ram_addr_o  = host1_addr_i;
         ram_wdata_o = host1_wdata_i;
      end
   end

   // -------------------------------------------------------------------------
   // Host outputs
   // -------------------------------------------------------------------------
   assign init_done_o    = (state_q == StServe);
   assign host0_gnt_o    = gnt0;
   assign host1_gnt_o    = gnt1;
   assign host0_rvalid_o = rvalid_q && !rid_q;
   assign host1_rvalid_o = rvalid_q && rid_q;

   // Read data passes straight from the RAM. It is forced to 0 during reset
   // so that every output is quiet while rst_i is high.
   assign host0_rdata_o  = rst_i ? '0 : ram_rdata_i;
   assign host1_rdata_o  = rst_i ? '0 : ram_rdata_i;

endmodule

// File: tb/tb_prim_ram_2p_ctrl.sv
// tb/tb_prim_ram_2p_ctrl.sv - directed self-checking bench for prim_ram_2p_ctrl

module tb_prim_ram_2p_ctrl;

   localparam logic [31:0] IV = 32'hDEAD_BEEF;
   localparam logic [31:0] WV = 32'h1234_5678;

   logic clk;
   int   n_total;
   int   n_bad;

   // ---------------- instance A: Depth 128 ----------------
   logic        rst_a, a_init_req, a_init_done;
   logic        a_h0_req, a_h0_write, a_h1_req, a_h1_write;
   logic [6:0]  a_h0_addr, a_h1_addr;
   logic [31:0] a_h0_wdata, a_h1_wdata;
   logic        a_gnt0, a_gnt1, a_rv0, a_rv1;
   logic [31:0] a_rdata0, a_rdata1;
   logic        a_ram_req, a_ram_write;
   logic [6:0]  a_ram_addr;
   logic [31:0] a_ram_wdata, a_ram_rdata;
   logic [31:0] mem_a [128];

   prim_ram_2p_ctrl #(.Width(32), .Depth(128), .InitValue(IV)) u_dut_a (
      .clk_i(clk), .rst_i(rst_a),
      .init_req_i(a_init_req), .init_done_o(a_init_done),
      .host0_req_i(a_h0_req), .host0_write_i(a_h0_write), .host0_addr_i(a_h0_addr),
      .host0_wdata_i(a_h0_wdata), .host0_gnt_o(a_gnt0), .host0_rvalid_o(a_rv0),
      .host0_rdata_o(a_rdata0),
      .host1_req_i(a_h1_req), .host1_write_i(a_h1_write), .host1_addr_i(a_h1_addr),
      .host1_wdata_i(a_h1_wdata), .host1_gnt_o(a_gnt1), .host1_rvalid_o(a_rv1),
      .host1_rdata_o(a_rdata1),
      .ram_req_o(a_ram_req), .ram_write_o(a_ram_write), .ram_addr_o(a_ram_addr),
      .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata)
   );

   always @(posedge clk) begin
      if (a_ram_req) begin
         if (a_ram_write) mem_a[a_ram_addr] <= a_ram_wdata;
         else             a_ram_rdata       <= mem_a[a_ram_addr];
      end
   end

   // ---------------- instance B: Depth 100 ----------------
   logic        rst_b, b_init_done;
   logic        b_gnt0, b_gnt1, b_rv0, b_rv1;
   logic [31:0] b_rdata0, b_rdata1;
   logic        b_ram_req, b_ram_write;
   logic [6:0]  b_ram_addr;
   logic [31:0] b_ram_wdata;
   logic        zero1;
   logic [6:0]  zero7;
   logic [31:0] zero32;

   prim_ram_2p_ctrl #(.Width(32), .Depth(100), .InitValue(IV)) u_dut_b (
      .clk_i(clk), .rst_i(rst_b),
      .init_req_i(zero1), .init_done_o(b_init_done),
      .host0_req_i(zero1), .host0_write_i(zero1), .host0_addr_i(zero7),
      .host0_wdata_i(zero32), .host0_gnt_o(b_gnt0), .host0_rvalid_o(b_rv0),
      .host0_rdata_o(b_rdata0),
      .host1_req_i(zero1), .host1_write_i(zero1), .host1_addr_i(zero7),
      .host1_wdata_i(zero32), .host1_gnt_o(b_gnt1), .host1_rvalid_o(b_rv1),
      .host1_rdata_o(b_rdata1),
      .ram_req_o(b_ram_req), .ram_write_o(b_ram_write), .ram_addr_o(b_ram_addr),
      .ram_wdata_o(b_ram_wdata), .ram_rdata_i(zero32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] a_ctrl();
      return {18'd0, a_init_done, a_ram_req, a_ram_write, a_gnt0, a_gnt1, a_rv0, a_rv1, a_ram_addr};
   endfunction

   function automatic logic [31:0] b_ctrl();
      return {18'd0, b_init_done, b_ram_req, b_ram_write, b_gnt0, b_gnt1, b_rv0, b_rv1, b_ram_addr};
   endfunction

   initial begin
      int wr, aerr, derr, gseen, early, last_addr, first_addr, prev;
      logic [31:0] pdata;

      n_total = 0; n_bad = 0;
      rst_a = 1'b1; rst_b = 1'b1; a_init_req = 1'b0;
      a_h0_req = 0; a_h0_write = 0; a_h0_addr = '0; a_h0_wdata = '0;
      a_h1_req = 0; a_h1_write = 0; a_h1_addr = '0; a_h1_wdata = '0;
      zero1 = 1'b0; zero7 = '0; zero32 = '0;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_a_ctrl",  a_ctrl(), 32'd0);
      chk("rst_a_wdata", a_ram_wdata, 32'd0);
      chk("rst_a_rdata0", a_rdata0, 32'd0);
      chk("rst_b_ctrl",  b_ctrl(), 32'd0);

      // ---- init sweep, host0 read of addr 5 held pending throughout ----
      next_cyc();
      rst_a = 1'b0; a_h0_req = 1'b1; a_h0_write = 1'b0; a_h0_addr = 7'd5;
      wr = 0; aerr = 0; derr = 0; gseen = 0; early = 0; last_addr = -1;
      for (int k = 0; k <= 128; k++) begin
         @(negedge clk);
         if (a_gnt0 || a_gnt1) gseen++;
         if (a_init_done) early++;
         if (a_ram_req && a_ram_write) begin
            if (a_ram_addr !== 7'(wr)) aerr++;
            if (a_ram_wdata !== IV) derr++;
            last_addr = int'(a_ram_addr);
            wr++;
         end
      end
      chk("init_writes", 32'(wr), 32'd128);
      chk("init_addr_err", 32'(aerr), 32'd0);
      chk("init_data_err", 32'(derr), 32'd0);
      chk("init_last_addr", 32'(last_addr), 32'd127);
      chk("init_no_gnt", 32'(gseen), 32'd0);
      chk("init_done_early", 32'(early), 32'd0);
      @(negedge clk);
      chk("init_done_129", 32'(a_init_done), 32'd1);
      chk("rd5_gnt0", 32'(a_gnt0), 32'd1);
      chk("rd5_ram_addr", 32'(a_ram_addr), 32'd5);
      chk("rd5_ram_write", 32'(a_ram_write), 32'd0);

      // ---- rvalid for read 5; host1 writes 127 ----
      next_cyc();
      a_h0_req = 0; a_h1_req = 1; a_h1_write = 1; a_h1_addr = 7'd127; a_h1_wdata = WV;
      @(negedge clk);
      chk("rd5_rv0", 32'(a_rv0), 32'd1);
      chk("rd5_rdata0", a_rdata0, IV);
      chk("rd5_rv1", 32'(a_rv1), 32'd0);
      chk("wr_gnt1", 32'(a_gnt1), 32'd1);
      chk("wr_ram_wdata", a_ram_wdata, WV);

      // ---- host0 reads 127 ----
      next_cyc();
      a_h1_req = 0; a_h0_req = 1; a_h0_write = 0; a_h0_addr = 7'd127;
      @(negedge clk);
      chk("rd127_gnt0", 32'(a_gnt0), 32'd1);
      chk("wr_no_rvalid", 32'({a_rv0, a_rv1}), 32'd0);

      // ---- host1 reads 127 (sets last pointer to host1) ----
      next_cyc();
      a_h0_req = 0; a_h1_req = 1; a_h1_write = 0; a_h1_addr = 7'd127;
      @(negedge clk);
      chk("rd127_rv0", 32'(a_rv0), 32'd1);
      chk("rd127_rdata0", a_rdata0, WV);
      chk("rd127_gnt1", 32'(a_gnt1), 32'd1);

      // ---- contention: host0 reads 3, host1 reads 127 ----
      next_cyc();
      a_h0_req = 1; a_h0_addr = 7'd3;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("cont_gnt0_%0d", i), 32'(a_gnt0), 32'((i % 2) == 0));
         chk($sformatf("cont_gnt1_%0d", i), 32'(a_gnt1), 32'((i % 2) == 1));
         prev  = (i == 0) ? 1 : ((i - 1) % 2);
         pdata = (prev == 1) ? WV : IV;
         chk($sformatf("cont_rv_%0d", i), 32'({a_rv1, a_rv0}), (prev == 1) ? 32'd2 : 32'd1);
         chk($sformatf("cont_rdata_%0d", i), (prev == 1) ? a_rdata1 : a_rdata0, pdata);
         next_cyc();
      end

      // ---- re-init with a host0 read in flight ----
      a_h1_req = 0; a_h0_addr = 7'd5;
      @(negedge clk);
      chk("cont_last_rv1", 32'(a_rv1), 32'd1);
      chk("cont_last_rdata1", a_rdata1, WV);
      chk("pre_reinit_gnt0", 32'(a_gnt0), 32'd1);
      next_cyc();
      a_h0_req = 0; a_h1_req = 1; a_h1_addr = 7'd127; a_init_req = 1;
      @(negedge clk);
      chk("reinit_no_gnt", 32'({a_gnt0, a_gnt1, a_ram_req}), 32'd0);
      chk("reinit_rv0", 32'(a_rv0), 32'd1);
      chk("reinit_rdata0", a_rdata0, IV);
      chk("reinit_done_trig", 32'(a_init_done), 32'd1);
      next_cyc();
      a_init_req = 0;
      wr = 0; aerr = 0; derr = 0; gseen = 0; early = 0;
      for (int j = 0; j < 128; j++) begin
         @(negedge clk);
         if (a_gnt0 || a_gnt1) gseen++;
         if (a_init_done) early++;
         if (a_ram_req && a_ram_write) begin
            if (a_ram_addr !== 7'(wr)) aerr++;
            if (a_ram_wdata !== IV) derr++;
            wr++;
         end
      end
      chk("reinit_writes", 32'(wr), 32'd128);
      chk("reinit_addr_err", 32'(aerr), 32'd0);
      chk("reinit_data_err", 32'(derr), 32'd0);
      chk("reinit_no_gnt_sweep", 32'(gseen), 32'd0);
      chk("reinit_done_low", 32'(early), 32'd0);
      @(negedge clk);
      chk("reinit_done_back", 32'(a_init_done), 32'd1);
      chk("reinit_gnt1", 32'(a_gnt1), 32'd1);
      next_cyc();
      a_h1_req = 0;
      @(negedge clk);
      chk("reinit_rd127_rv1", 32'(a_rv1), 32'd1);
      chk("reinit_rd127_data", a_rdata1, IV);

      // ---- instance B: reset mid-INIT at init_cnt 40 ----
      next_cyc();
      rst_b = 1'b0;
      repeat (42) @(negedge clk);
      chk("b_at40_addr", 32'(b_ram_addr), 32'd40);
      chk("b_at40_req", 32'(b_ram_req), 32'd1);
      rst_b = 1'b1;
      #1;
      chk("b_rst_ctrl", b_ctrl(), 32'd0);
      chk("b_rst_wdata", b_ram_wdata, 32'd0);
      next_cyc();
      rst_b = 1'b0;
      wr = 0; aerr = 0; early = 0; first_addr = -1; last_addr = -1;
      for (int k = 0; k <= 100; k++) begin
         @(negedge clk);
         if (b_init_done) early++;
         if (b_ram_req && b_ram_write) begin
            if (b_ram_addr !== 7'(wr)) aerr++;
            if (first_addr < 0) first_addr = int'(b_ram_addr);
            last_addr = int'(b_ram_addr);
            wr++;
         end
      end
      chk("b_writes", 32'(wr), 32'd100);
      chk("b_first_addr", 32'(first_addr), 32'd0);
      chk("b_last_addr", 32'(last_addr), 32'd99);
      chk("b_addr_err", 32'(aerr), 32'd0);
      chk("b_done_early", 32'(early), 32'd0);
      @(negedge clk);
      chk("b_done", 32'(b_init_done), 32'd1);
      chk("b_idle", 32'(b_ram_req), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
